// File: rtl/um_program_loader.sv
// um_program_loader
// Boot-time loader that fills memory array 0 with a UM program before the
// control unit starts. It takes a byte stream over a valid/ready handshake.
// The stream is a 4-byte big-endian word count followed by the program
// words, each big-endian. Every 4 bytes are packed into a 32-bit word and
// written to array 0 with a single mode=01 cycle on the mem_in bus.
//
// The mem_in bus is flattened into four ports:
//   mem_in_mode, mem_in_address, mem_in_offset, mem_in_data.
//
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   start          in   single-cycle pulse; begins a load from IDLE only
//   in_valid       in   in_data carries a valid byte
//   in_data[7:0]   in   stream byte, most significant byte of a word first
//   in_ready       out  a byte is accepted this cycle (HDR/DATA)
//   mem_in_mode    out  2'b01 = write, 2'b00 = idle (registered)
//   mem_in_address out  array index, always 0 (registered)
//   mem_in_offset  out  word offset within array 0 (registered)
//   mem_in_data    out  word to write (registered)
//   bus_enable     out  enable for this block's mem_in_bus_buf
//   cu_reset       out  holds control_unit in reset; low only in DONE
//   done           out  program fully written
//   error          out  header exceeded MAX_WORDS
//   words_loaded   out  number of words written so far
//
// state | meaning
// IDLE  | waiting for start
// HDR   | assembling the 4-byte word count
// DATA  | assembling program words and issuing writes
// DONE  | load complete, control unit released (sticky)
// ERR   | word count too large (sticky)

module um_program_loader #(
  parameter logic [31:0] MAX_WORDS = 32'd65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [1:0]  mem_in_mode,
  output logic [31:0] mem_in_address,
  output logic [31:0] mem_in_offset,
  output logic [31:0] mem_in_data,
  output logic        bus_enable,
  output logic        cu_reset,
  output logic        done,
  output logic        error,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] word;
  logic [31:0] len;
  logic [1:0]  byte_cnt;
  logic        accept;
  logic        word_end;
  logic        write_cyc;
  logic [31:0] assembled;

  // Status outputs depend only on the state register, so the handshake
  // never loops back through the next-state logic.
  assign in_ready   = (state == HDR) || (state == DATA);
  assign bus_enable = in_ready;
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign cu_reset   = (state != DONE);

  assign accept    = in_valid && in_ready;
  assign assembled = {word[23:0], in_data};
  assign word_end  = accept && (byte_cnt == 2'd3);
  assign write_cyc = (mem_in_mode == 2'b01);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = HDR;
      HDR: begin
        if (word_end) begin
          if (assembled == 32'd0)           state_nxt = DONE;
          else if (assembled > MAX_WORDS)   state_nxt = ERR;
          else                              state_nxt = DATA;
        end
      end
      // The final write cycle is on the bus now; leave DATA as it ends.
      DATA: if (write_cyc && (words_loaded + 32'd1 == len)) state_nxt = DONE;
      DONE: state_nxt = DONE;
      ERR:  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word           <= '0;
      byte_cnt       <= '0;
      len            <= '0;
      words_loaded   <= '0;
      mem_in_mode    <= 2'b00;
      mem_in_address <= '0;
      mem_in_offset  <= '0;
      mem_in_data    <= '0;
    end else begin
      mem_in_mode <= 2'b00;
      if ((state == IDLE) && start) begin
        word     <= '0;
        byte_cnt <= '0;
      end
      // A gap in in_valid holds both the partial word and the byte count.
      if (accept) begin
        word     <= assembled;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if ((state == HDR) && word_end) len <= assembled;
      // The write cycle overlaps assembly of the next word, which cannot
      // complete before this one has left the bus.
      if ((state == DATA) && word_end) begin
        mem_in_mode    <= 2'b01;
        mem_in_address <= '0;
        mem_in_offset  <= words_loaded;
        mem_in_data    <= assembled;
      end
      if (write_cyc) words_loaded <= words_loaded + 32'd1;
    end
  end

endmodule
